// File: rtl/mem_wb_stage_ws.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_ws
//   MEM->WB pipeline register with wait-state data-memory support.
//   Captures the writeback control of the MEM-stage instruction, extracts and
//   sign/zero-extends load data from the 32-bit DM read word by byte offset,
//   and rides out multi-cycle DM responses, downstream hold and flush.
//
// Handshake summary (single place):
//   - dm_rvalid qualifies DM_OUT for exactly the cycle it is high; a response
//     that is not consumed or buffered that cycle is lost.
//   - hold_WB high freezes every WB register; nothing new is accepted.
//   - stall_req high means "MEM and earlier must re-present the same
//     instruction next cycle". It is combinational from state and inputs.
//   - flush beats hold_WB; rst beats both.
//
// Parameters
//   XLEN        datapath width, 32 or 64 only
//   RD_AW       rd address width (msb selects the FP register file)
//   ALIGN_LOADS 1: lane chosen by addr[1:0]; 0: low lanes always
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   valid_MEM, wb_en_MEM, fwb_en_MEM, is_load_MEM, rd_addr_MEM, alu_out_MEM
//                                  MEM-stage instruction and control
//   DM_OUT, dm_rvalid              DM read word and its valid strobe
//   hold_WB, flush                 downstream hold, pipeline kill
//   stall_req                      stall MEM and earlier stages
//   valid_WB, wb_en_WB, fwb_en_WB, rd_addr_WB, wb_data_WB, ld_fault_WB
//                                  registered writeback outputs
//   dbg_state                      current FSM state (0 IDLE, 1 WAIT_DM,
//                                  2 DATA_HELD) for checkers
// -----------------------------------------------------------------------------
module mem_wb_stage_ws #(
   parameter int XLEN        = 32,
   parameter int RD_AW       = 6,
   parameter int ALIGN_LOADS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_MEM,
   input  logic             wb_en_MEM,
   input  logic             fwb_en_MEM,
   input  logic [2:0]       is_load_MEM,
   input  logic [RD_AW-1:0] rd_addr_MEM,
   input  logic [XLEN-1:0]  alu_out_MEM,
   input  logic [31:0]      DM_OUT,
   input  logic             dm_rvalid,
   input  logic             hold_WB,
   input  logic             flush,
   output logic             stall_req,
   output logic             valid_WB,
   output logic             wb_en_WB,
   output logic             fwb_en_WB,
   output logic [RD_AW-1:0] rd_addr_WB,
   output logic [XLEN-1:0]  wb_data_WB,
   output logic             ld_fault_WB,
   output logic [1:0]       dbg_state
);

   localparam logic [2:0] LD_NONE = 3'b000;
   localparam logic [2:0] LD_LB   = 3'b001;
   localparam logic [2:0] LD_LH   = 3'b010;
   localparam logic [2:0] LD_LW   = 3'b011;
   localparam logic [2:0] LD_LBU  = 3'b100;
   localparam logic [2:0] LD_LHU  = 3'b101;
   localparam logic [2:0] LD_LWU  = 3'b110;
   localparam logic [2:0] LD_ILL  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_DM   = 2'd1,
      S_DATA_HELD = 2'd2
   } state_t;

   state_t state, next_state;

   // Load context latched when the DM response is late.
   logic             lat_wb_en;
   logic             lat_fwb_en;
   logic [RD_AW-1:0] lat_rd;
   logic [2:0]       lat_code;
   logic [1:0]       lat_off;
   logic [31:0]      buf_data;

   // FSM output strobes.
   logic wb_write;
   logic wb_bubble;
   logic latch_load;
   logic capture_buf;

   // The illegal code 111 never issues a DM access, so it faults straight
   // through IDLE instead of waiting for a response that may never come.
   logic needs_dm;
   assign needs_dm = (is_load_MEM != LD_NONE) && (is_load_MEM != LD_ILL);

   logic [1:0] mem_off;
   assign mem_off = (ALIGN_LOADS != 0) ? alu_out_MEM[1:0] : 2'b00;

   // ---------------------------------------------------------------------------
   // Source select: in IDLE the live MEM instruction is written; after a late
   // response the latched context is used, with DM_OUT or the held buffer.
   // ---------------------------------------------------------------------------
   logic             sel_wb_en;
   logic             sel_fwb_en;
   logic [RD_AW-1:0] sel_rd;
   logic [2:0]       sel_code;
   logic [1:0]       sel_off;
   logic [31:0]      sel_word;

   always_comb begin
      sel_wb_en  = lat_wb_en;
      sel_fwb_en = lat_fwb_en;
      sel_rd     = lat_rd;
      sel_code   = lat_code;
      sel_off    = lat_off;
      sel_word   = DM_OUT;
      if (state == S_IDLE) begin
         sel_wb_en  = wb_en_MEM;
         sel_fwb_en = fwb_en_MEM;
         sel_rd     = rd_addr_MEM;
         sel_code   = is_load_MEM;
         sel_off    = mem_off;
      end else if (state == S_DATA_HELD) begin
         sel_word = buf_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Lane extraction, extension and fault detection.
   // ---------------------------------------------------------------------------
   logic [7:0]      byte_v;
   logic [15:0]     half_v;
   logic            res_fault;
   logic [XLEN-1:0] res_data;

   always_comb begin
      byte_v = sel_word[{sel_off, 3'b000} +: 8];
      half_v = sel_word[{sel_off[1], 4'b0000} +: 16];

      case (sel_code)
         LD_LH, LD_LHU: res_fault = sel_off[0];
         LD_LW:         res_fault = (sel_off != 2'b00);
         LD_LWU:        res_fault = (sel_off != 2'b00) || (XLEN == 32);
         LD_ILL:        res_fault = 1'b1;
         default:       res_fault = 1'b0;
      endcase

      // Size casts of signed operands sign-extend; unsigned ones zero-extend.
      case (sel_code)
         LD_LB:   res_data = XLEN'($signed(byte_v));
         LD_LBU:  res_data = XLEN'(byte_v);
         LD_LH:   res_data = XLEN'($signed(half_v));
         LD_LHU:  res_data = XLEN'(half_v);
         LD_LW:   res_data = XLEN'($signed(sel_word));
         LD_LWU:  res_data = XLEN'(sel_word);
         LD_NONE: res_data = alu_out_MEM;
         default: res_data = '0;
      endcase

      if (res_fault) begin
         res_data = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      if (flush) begin
         next_state = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (!hold_WB && valid_MEM && needs_dm && !dm_rvalid) begin
                  next_state = S_WAIT_DM;
               end
            end
            S_WAIT_DM: begin
               if (dm_rvalid) begin
                  next_state = hold_WB ? S_DATA_HELD : S_IDLE;
               end
            end
            S_DATA_HELD: begin
               if (!hold_WB) begin
                  next_state = S_IDLE;
               end
            end
            default: next_state = S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs and datapath strobes
   // ---------------------------------------------------------------------------
   always_comb begin
      stall_req   = 1'b0;
      wb_write    = 1'b0;
      wb_bubble   = 1'b0;
      latch_load  = 1'b0;
      capture_buf = 1'b0;
      if (rst) begin
         stall_req = 1'b0;
      end else if (flush) begin
         // The killed instruction is replaced by a bubble; MEM may move on.
         wb_bubble = 1'b1;
      end else begin
         stall_req = hold_WB;
         case (state)
            S_IDLE: begin
               if (!hold_WB) begin
                  if (!valid_MEM) begin
                     wb_bubble = 1'b1;
                  end else if (needs_dm && !dm_rvalid) begin
                     stall_req  = 1'b1;
                     latch_load = 1'b1;
                     wb_bubble  = 1'b1;
                  end else begin
                     wb_write = 1'b1;
                  end
               end
            end
            S_WAIT_DM: begin
               stall_req = 1'b1;
               if (dm_rvalid) begin
                  if (hold_WB) begin
                     capture_buf = 1'b1;
                  end else begin
                     wb_write = 1'b1;
                  end
               end else if (!hold_WB) begin
                  wb_bubble = 1'b1;
               end
            end
            S_DATA_HELD: begin
               stall_req = 1'b1;
               if (!hold_WB) begin
                  wb_write = 1'b1;
               end
            end
            default: stall_req = 1'b1;
         endcase
      end
   end

   assign dbg_state = state;

   // ---------------------------------------------------------------------------
   // Pending-load context and response buffer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         lat_wb_en  <= 1'b0;
         lat_fwb_en <= 1'b0;
         lat_rd     <= '0;
         lat_code   <= LD_NONE;
         lat_off    <= 2'b00;
         buf_data   <= '0;
      end else begin
         if (latch_load) begin
            lat_wb_en  <= wb_en_MEM;
            lat_fwb_en <= fwb_en_MEM;
            lat_rd     <= rd_addr_MEM;
            lat_code   <= is_load_MEM;
            lat_off    <= mem_off;
         end
         if (capture_buf) begin
            buf_data <= DM_OUT;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // WB registers. A bubble clears valid, enables and fault but leaves rd and
   // data as they were.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_WB    <= 1'b0;
         wb_en_WB    <= 1'b0;
         fwb_en_WB   <= 1'b0;
         rd_addr_WB  <= '0;
         wb_data_WB  <= '0;
         ld_fault_WB <= 1'b0;
      end else if (wb_write) begin
         valid_WB    <= 1'b1;
         wb_en_WB    <= sel_wb_en & ~res_fault;
         fwb_en_WB   <= sel_fwb_en & ~res_fault;
         rd_addr_WB  <= sel_rd;
         wb_data_WB  <= res_data;
         ld_fault_WB <= res_fault;
      end else if (wb_bubble) begin
         valid_WB    <= 1'b0;
         wb_en_WB    <= 1'b0;
         fwb_en_WB   <= 1'b0;
         ld_fault_WB <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage_ws.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage_ws
//   Drives a 32-bit and a 64-bit instance of mem_wb_stage_ws with identical
//   stimulus and checks both against a transaction-level reference: a queue
//   holding at most one outstanding load, an optional held DM word, and the
//   load-result rules written as plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage_ws;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        valid_mem = 1'b0, wb_en_mem = 1'b0, fwb_en_mem = 1'b0;
   logic [2:0]  is_load_mem = 3'd0;
   logic [5:0]  rd_addr_mem = 6'd0;
   logic [63:0] alu_out_mem = 64'd0;
   logic [31:0] dm_out = 32'd0;
   logic        dm_rvalid = 1'b0, hold_wb = 1'b0, flush = 1'b0;

   logic        stall32, valid32, en32, fen32, flt32;
   logic [5:0]  rd32;
   logic [31:0] data32;
   logic [1:0]  st32;
   logic        stall64, valid64, en64, fen64, flt64;
   logic [5:0]  rd64;
   logic [63:0] data64;
   logic [1:0]  st64;

   mem_wb_stage_ws #(.XLEN(32), .RD_AW(6), .ALIGN_LOADS(1)) dut32 (
      .clk(clk), .rst(rst), .valid_MEM(valid_mem), .wb_en_MEM(wb_en_mem),
      .fwb_en_MEM(fwb_en_mem), .is_load_MEM(is_load_mem), .rd_addr_MEM(rd_addr_mem),
      .alu_out_MEM(alu_out_mem[31:0]), .DM_OUT(dm_out), .dm_rvalid(dm_rvalid),
      .hold_WB(hold_wb), .flush(flush), .stall_req(stall32), .valid_WB(valid32),
      .wb_en_WB(en32), .fwb_en_WB(fen32), .rd_addr_WB(rd32), .wb_data_WB(data32),
      .ld_fault_WB(flt32), .dbg_state(st32)
   );

   mem_wb_stage_ws #(.XLEN(64), .RD_AW(6), .ALIGN_LOADS(1)) dut64 (
      .clk(clk), .rst(rst), .valid_MEM(valid_mem), .wb_en_MEM(wb_en_mem),
      .fwb_en_MEM(fwb_en_mem), .is_load_MEM(is_load_mem), .rd_addr_MEM(rd_addr_mem),
      .alu_out_MEM(alu_out_mem), .DM_OUT(dm_out), .dm_rvalid(dm_rvalid),
      .hold_WB(hold_wb), .flush(flush), .stall_req(stall64), .valid_WB(valid64),
      .wb_en_WB(en64), .fwb_en_WB(fen64), .rd_addr_WB(rd64), .wb_data_WB(data64),
      .ld_fault_WB(flt64), .dbg_state(st64)
   );

   // ---------------- scoreboard / checker ----------------
   int n_vectors = 0;
   int n_miscompares = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        v;
      logic        en;
      logic        fen;
      logic        flt;
      logic [5:0]  rd;
      logic [63:0] data;
   } wb_t;

   typedef struct packed {
      logic [2:0] code;
      logic [1:0] off;
      logic       we;
      logic       fe;
      logic [5:0] rd;
   } pend_t;

   wb_t         e32, e64;
   pend_t       pend_q[$];
   bit          have_buf;
   logic [31:0] held_word;

   function automatic wb_t wb_result(input int xlen, input logic [2:0] code,
                                     input logic [1:0] off, input logic [31:0] word,
                                     input logic [63:0] alu, input logic we,
                                     input logic fe, input logic [5:0] rd);
      wb_t r;
      longint unsigned v, w;
      int o;
      bit bad;
      o = int'(off);
      w = longint'(word);
      bad = (code == 3'd7) ||
            ((code == 3'd2 || code == 3'd5) && (o % 2 == 1)) ||
            ((code == 3'd3 || code == 3'd6) && o != 0) ||
            (code == 3'd6 && xlen == 32);
      v = 0;
      case (code)
         3'd0: v = alu;
         3'd1, 3'd4: begin
            v = (w >> (8 * o)) % 256;
            if (code == 3'd1 && v >= 128) v = v - 256;
         end
         3'd2, 3'd5: begin
            v = (w >> (16 * (o / 2))) % 65536;
            if (code == 3'd2 && v >= 32768) v = v - 65536;
         end
         3'd3, 3'd6: begin
            v = w;
            if (code == 3'd3 && v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
         end
         default: v = 0;
      endcase
      if (xlen == 32) v = v % 64'h1_0000_0000;
      r.v  = 1'b1;
      r.rd = rd;
      if (bad) begin
         r.en = 1'b0; r.fen = 1'b0; r.flt = 1'b1; r.data = 64'd0;
      end else begin
         r.en = we; r.fen = fe; r.flt = 1'b0; r.data = v;
      end
      return r;
   endfunction

   function automatic wb_t bubble(input wb_t cur);
      wb_t r;
      r = cur;
      r.v = 1'b0; r.en = 1'b0; r.fen = 1'b0; r.flt = 1'b0;
      return r;
   endfunction

   // ---------------- driver ----------------
   task automatic apply(input logic r, input logic v, input logic we, input logic fe,
                        input logic [2:0] code, input logic [5:0] rd,
                        input logic [63:0] alu, input logic [31:0] dm,
                        input logic rv, input logic h, input logic f);
      logic  exp_stall;
      pend_t p;
      logic [31:0] word;
      @(negedge clk);
      rst = r; valid_mem = v; wb_en_mem = we; fwb_en_mem = fe;
      is_load_mem = code; rd_addr_mem = rd; alu_out_mem = alu;
      dm_out = dm; dm_rvalid = rv; hold_wb = h; flush = f;
      #1;
      exp_stall = !r && !f && (h || pend_q.size() != 0 ||
                               (v && code != 3'd0 && code != 3'd7 && !rv));
      check("stall32", 64'(stall32), 64'(exp_stall));
      check("stall64", 64'(stall64), 64'(exp_stall));

      // advance the reference by one clock
      if (r) begin
         e32 = '0; e64 = '0; pend_q.delete(); have_buf = 0;
      end else if (f) begin
         e32 = bubble(e32); e64 = bubble(e64); pend_q.delete(); have_buf = 0;
      end else if (h) begin
         if (pend_q.size() != 0 && !have_buf && rv) begin
            have_buf = 1; held_word = dm;
         end
      end else if (pend_q.size() != 0) begin
         if (have_buf || rv) begin
            word = have_buf ? held_word : dm;
            p = pend_q.pop_front();
            have_buf = 0;
            e32 = wb_result(32, p.code, p.off, word, 64'd0, p.we, p.fe, p.rd);
            e64 = wb_result(64, p.code, p.off, word, 64'd0, p.we, p.fe, p.rd);
         end else begin
            e32 = bubble(e32); e64 = bubble(e64);
         end
      end else if (!v) begin
         e32 = bubble(e32); e64 = bubble(e64);
      end else if (code == 3'd0 || code == 3'd7 || rv) begin
         e32 = wb_result(32, code, alu[1:0], dm, alu, we, fe, rd);
         e64 = wb_result(64, code, alu[1:0], dm, alu, we, fe, rd);
      end else begin
         p.code = code; p.off = alu[1:0]; p.we = we; p.fe = fe; p.rd = rd;
         pend_q.push_back(p);
         e32 = bubble(e32); e64 = bubble(e64);
      end

      @(posedge clk);
      #1;
      check("ctl32",  64'({valid32, en32, fen32, flt32, rd32}),
                      64'({e32.v, e32.en, e32.fen, e32.flt, e32.rd}));
      check("data32", 64'(data32), 64'(e32.data[31:0]));
      check("ctl64",  64'({valid64, en64, fen64, flt64, rd64}),
                      64'({e64.v, e64.en, e64.fen, e64.flt, e64.rd}));
      check("data64", data64, e64.data);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      e32 = '0; e64 = '0; have_buf = 0; held_word = '0;

      // Reset, then reset again while a load waits for DM.
      apply(1, 0, 0, 0, 3'd0, 6'd0, 64'd0, 32'd0, 0, 0, 0);
      apply(1, 0, 0, 0, 3'd0, 6'd0, 64'd0, 32'd0, 0, 0, 0);
      apply(0, 1, 1, 0, 3'd1, 6'd5, 64'h100, 32'd0, 0, 0, 0);
      apply(0, 1, 1, 0, 3'd1, 6'd5, 64'h100, 32'd0, 0, 0, 0);
      apply(1, 1, 1, 0, 3'd1, 6'd5, 64'h100, 32'd0, 0, 0, 0);
      check("rst_out32", 64'({valid32, en32, fen32, flt32, rd32, data32}), 64'd0);
      check("rst_data64", data64, 64'd0);
      apply(0, 0, 0, 0, 3'd0, 6'd0, 64'd0, 32'd0, 0, 0, 0);
      check("rst_state", 64'(st32), 64'd0);

      // LB at offset 3 with immediate response.
      apply(0, 1, 1, 0, 3'd1, 6'd7, 64'h1003, 32'h80FF_1234, 1, 0, 0);
      check("lb_data32", 64'(data32), 64'h0000_0000_FFFF_FF80);
      check("lb_data64", data64, 64'hFFFF_FFFF_FFFF_FF80);

      // LHU at offset 2, response three cycles late.
      for (int i = 0; i < 3; i++)
         apply(0, 1, 1, 0, 3'd5, 6'd8, 64'h2002, 32'hAAAA_AAAA, 0, 0, 0);
      apply(0, 1, 1, 0, 3'd5, 6'd8, 64'h2002, 32'hBEEF_0001, 1, 0, 0);
      check("lhu_data32", 64'(data32), 64'h0000_BEEF);
      check("lhu_data64", data64, 64'h0000_BEEF);

      // LW answered while WB is held for two cycles.
      apply(0, 1, 1, 0, 3'd3, 6'd9, 64'h3000, 32'd0, 0, 0, 0);
      apply(0, 1, 1, 0, 3'd3, 6'd9, 64'h3000, 32'h1234_5678, 1, 1, 0);
      apply(0, 1, 1, 0, 3'd3, 6'd9, 64'h3000, 32'h0, 0, 1, 0);
      check("hold_valid", 64'(valid32), 64'd0);
      apply(0, 1, 1, 0, 3'd3, 6'd9, 64'h3000, 32'h0, 0, 0, 0);
      check("held_lw32", 64'(data32), 64'h1234_5678);
      check("held_rd32", 64'(rd32), 64'd9);

      // Flush while waiting, stray response, then an ALU op.
      apply(0, 1, 1, 0, 3'd3, 6'd10, 64'h3100, 32'd0, 0, 0, 0);
      apply(0, 1, 1, 0, 3'd3, 6'd10, 64'h3100, 32'd0, 0, 0, 1);
      apply(0, 0, 0, 0, 3'd0, 6'd0, 64'd0, 32'hDEAD_BEEF, 1, 0, 0);
      check("stray_valid", 64'(valid32), 64'd0);
      apply(0, 1, 1, 0, 3'd0, 6'd11, 64'h42, 32'd0, 0, 0, 0);
      check("alu_data32", 64'(data32), 64'h42);
      check("alu_valid", 64'(valid32), 64'd1);

      // Misaligned LW and LWU on both widths.
      apply(0, 1, 1, 0, 3'd3, 6'd12, 64'h4002, 32'h1111_2222, 1, 0, 0);
      check("lw_fault", 64'({flt32, en32, valid32}), 64'b101);
      apply(0, 1, 1, 0, 3'd6, 6'd13, 64'h5000, 32'hFFFF_FFFF, 1, 0, 0);
      check("lwu_data64", data64, 64'h0000_0000_FFFF_FFFF);
      check("lwu_fault32", 64'(flt32), 64'd1);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         apply($urandom_range(0, 99) < 2,
               $urandom_range(0, 99) < 80,
               1'($urandom), 1'($urandom),
               3'($urandom_range(0, 7)), 6'($urandom),
               {$urandom, $urandom}, $urandom,
               $urandom_range(0, 99) < 50,
               $urandom_range(0, 99) < 20,
               $urandom_range(0, 99) < 5);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
